// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Also used by the reusable two-way round-robin arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned DefXlen     = 32;
    localparam int unsigned DefNregLog2 = 5;

    typedef enum logic {
        StArb   = 1'b0,
        StClear = 1'b1
    } state_e;

    // Source index doubles as the bit position in request/grant vectors.
    typedef enum logic {
        SrcAlu = 1'b0,
        SrcMem = 1'b1
    } src_e;

    function automatic logic [1:0] src_onehot(src_e src);
        return (src == SrcAlu) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/accept signals plus the register-file write port.
// The master side is the pipeline, the slave side is the arbiter.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN      = DefXlen,
    parameter int unsigned NREG_LOG2 = DefNregLog2
);

    logic                 alu_valid;
    logic [NREG_LOG2-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 alu_ready;

    logic                 mem_valid;
    logic [NREG_LOG2-1:0] mem_rd;
    logic [XLEN-1:0]      mem_data;
    logic                 mem_ready;

    logic                 clear_req;
    logic                 busy;
    logic                 clear_done;

    logic                 rf_we;
    logic [NREG_LOG2-1:0] rf_rd;
    logic [XLEN-1:0]      rf_wdata;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output clear_req,
        input  alu_ready, mem_ready, busy, clear_done,
        input  rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  clear_req,
        output alu_ready, mem_ready, busy, clear_done,
        output rf_we, rf_rd, rf_wdata
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: on a conflict the source that did not win last time wins.
// last_grant only moves when advance is high and something is granted.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] request,
    input  logic       advance,
    output logic [1:0] grant
);

    src_e last_grant_q, last_grant_d;

    always_comb begin
        grant = 2'b00;
        unique case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == SrcMem) ? src_onehot(SrcAlu) : src_onehot(SrcMem);
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && grant[SrcAlu]) begin
            last_grant_d = SrcAlu;
        end else if (advance && grant[SrcMem]) begin
            last_grant_d = SrcMem;
        end
    end

    // Reset to MEM so that ALU wins the first conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= SrcMem;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: arbitrates ALU vs load writeback and runs a
// clear sequence that zeroes x1..x(2**NREG_LOG2-1) without a global reset.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN      = DefXlen,
    parameter int unsigned NREG_LOG2 = DefNregLog2
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
);

    localparam logic [NREG_LOG2-1:0] CntFirst = NREG_LOG2'(1);
    localparam logic [NREG_LOG2-1:0] CntLast  = '1;

    state_e               state_q, state_d;
    logic [NREG_LOG2-1:0] cnt_q, cnt_d;
    logic                 rf_we_q, rf_we_d;
    logic [NREG_LOG2-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 clear_done_q, clear_done_d;

    logic                 arb_en;
    logic [1:0]           request;
    logic [1:0]           grant;

    // A pending clear request blocks arbitration in the same cycle.
    always_comb begin
        arb_en  = (state_q == StArb) && !bus.clear_req;
        request = {bus.mem_valid, bus.alu_valid} & {2{arb_en}};
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .request (request),
        .advance (arb_en),
        .grant   (grant)
    );

    assign bus.alu_ready = grant[SrcAlu];
    assign bus.mem_ready = grant[SrcMem];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wdata_d   = rf_wdata_q;
        clear_done_d = 1'b0;

        unique case (state_q)
            StArb: begin
                if (bus.clear_req) begin
                    state_d = StClear;
                    cnt_d   = CntFirst;
                end else if (grant[SrcAlu]) begin
                    rf_we_d    = |bus.alu_rd;
                    rf_rd_d    = bus.alu_rd;
                    rf_wdata_d = bus.alu_data;
                end else if (grant[SrcMem]) begin
                    rf_we_d    = |bus.mem_rd;
                    rf_rd_d    = bus.mem_rd;
                    rf_wdata_d = bus.mem_data;
                end
            end
            StClear: begin
                rf_we_d    = 1'b1;
                rf_rd_d    = cnt_q;
                rf_wdata_d = '0;
                cnt_d      = cnt_q + NREG_LOG2'(1);
                if (cnt_q == CntLast) begin
                    state_d      = StArb;
                    cnt_d        = CntFirst;
                    clear_done_d = 1'b1;
                end
            end
            default: begin
                state_d = StArb;
                cnt_d   = CntFirst;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StArb;
            cnt_q        <= CntFirst;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign bus.busy       = (state_q == StClear);
    assign bus.clear_done = clear_done_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wdata   = rf_wdata_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        !(bus.alu_ready && bus.mem_ready));

    a_no_grant_busy: assert property (@(posedge clk) disable iff (reset)
        bus.busy |-> !(bus.alu_ready || bus.mem_ready));

    a_done_last: assert property (@(posedge clk) disable iff (reset)
        bus.clear_done |-> (bus.rf_we && bus.rf_rd == CntLast && bus.rf_wdata == '0));

endmodule
